// File: rtl/vector_out_pkg.sv
// Shared types and defaults for the vector output streamer.
package vector_out_pkg;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_VECTOR_SIZE = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/vector_fifo.sv
// Circular vector FIFO; a push while full is legal only when a pop happens in the same cycle.
module vector_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    assign dout  = r_mem[r_rd];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    always_ff @(posedge clock) begin
        if (push) r_mem[r_wr] <= din;
    end

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + PW'(1);
            if (pop)  r_rd <= r_rd + PW'(1);
            if (push && !pop)      r_count <= r_count + CW'(1);
            else if (pop && !push) r_count <= r_count - CW'(1);
        end
    end
endmodule

// File: rtl/vector_out_streamer.sv
// Buffers CPU output vectors and streams them element by element over a valid/ready port.
// Optional transfer counter output elemCount when VECTOR_OUT_STREAMER_COUNT_EN is defined.
module vector_out_streamer
    import vector_out_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vecIn,
    input  logic                              vecValid,
    output logic [DATA_WIDTH-1:0]             elemData,
    output logic                              elemValid,
    input  logic                              elemReady,
    output logic                              elemLast,
    output logic [$clog2(VECTOR_SIZE)-1:0]    elemIndex,
    output logic [$clog2(FIFO_DEPTH):0]       fifoCount,
    output logic                              overflow
`ifdef VECTOR_OUT_STREAMER_COUNT_EN
    ,output logic [31:0]                      elemCount
`endif
);
    localparam int VW = VECTOR_SIZE * DATA_WIDTH;
    localparam int IW = $clog2(VECTOR_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);

    state_t        r_state;
    state_t        w_next;
    logic [VW-1:0] r_shift;
    logic [IW-1:0] r_idx;
    logic          r_overflow;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_xfer;
    logic [VW-1:0] w_head;

    vector_fifo #(.WIDTH(VW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .din   (vecIn),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifoCount)
    );

    // A full FIFO still accepts a vector when the head leaves in the same cycle.
    assign w_push    = vecValid && (!w_full || w_pop);
    assign w_xfer    = elemValid && elemReady;
    assign elemLast  = (r_state == STREAM) && (r_idx == LAST_IDX);
    assign elemData  = r_shift[DATA_WIDTH-1:0];
    assign elemIndex = r_idx;
    assign overflow  = r_overflow;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next = STREAM;
            STREAM:  if (elemReady && elemLast && w_empty) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        elemValid = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            IDLE:   w_pop = !w_empty;
            STREAM: begin
                elemValid = 1'b1;
                w_pop     = elemReady && (r_idx == LAST_IDX) && !w_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_shift <= w_head;
                r_idx   <= '0;
            end else if (w_xfer) begin
                r_shift <= r_shift >> DATA_WIDTH;
                r_idx   <= r_idx + IW'(1);
            end
            if (vecValid && !w_push) r_overflow <= 1'b1;
        end
    end

`ifdef VECTOR_OUT_STREAMER_COUNT_EN
    logic [31:0] r_count;
    assign elemCount = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      r_count <= '0;
        else if (w_xfer) r_count <= r_count + 32'd1;
    end
`endif
endmodule
